rot_addr_gen: RTL and testbench
===============================

// Module: rot_addr_gen
// PURPOSE
//  Parametrised successor to the pixel address core of the rotate engine.
//  Walks the source image in raster order and emits one source/destination
//  byte-address pair per beat to the DMA for 0/90/180/270 deg CW/CCW rotation.
//  Supports any HEIGHT x WIDTH and CHANNELS bytes/pixel. Addressing is
//  incremental; multipliers are used in the SETUP cycle only.
// PARAMETERS
//  DIM_W    16  width of I_HEIGHT / I_WIDTH
//  ADDR_W   32  byte-address width; all address arithmetic is modulo 2^ADDR_W
//  CHANNELS 3   bytes per pixel; address stride, >=1
// PORTS
//  I_HCLK       in   1       clock; the only clock
//  I_HRESET     in   1       synchronous reset, active-high
//  I_START      in   1       start pulse; sampled only in IDLE
//  I_HEIGHT     in   DIM_W   source rows H; sampled on start
//  I_WIDTH      in   DIM_W   source cols W; sampled on start
//  I_DEGREES    in   2       0=0, 1=90, 2=180, 3=270; sampled on start
//  I_DIRECTION  in   1       0=CW, 1=CCW; sampled on start
//  I_SRC_BASE   in   ADDR_W  source image base; sampled on start
//  I_DST_BASE   in   ADDR_W  destination image base; sampled on start
//  I_DMA_READY  in   1       DMA accepts the current beat
//  O_VALID      out  1       beat valid
//  O_SRC_ADDR   out  ADDR_W  source pixel byte address
//  O_DST_ADDR   out  ADDR_W  destination pixel byte address
//  O_LAST       out  1       current beat is the final pixel
//  O_BUSY       out  1       high in SETUP/RUN/DONE
//  O_DONE       out  1       one-cycle pulse at end of job
//  O_ERR        out  1       one-cycle pulse alongside O_DONE when H==0 or W==0
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; counters 0. Reset mid-job aborts at the
//    same edge with no DONE pulse.
//  - Effective CW rotation: rot = I_DIRECTION ? (-I_DEGREES)&3 : I_DEGREES.
//  - FSM: IDLE -(START)-> SETUP -> RUN -(last beat accepted)-> DONE -> IDLE.
//    START with H==0 or W==0: IDLE -> DONE, no beats, O_ERR=1 with O_DONE.
//    START while not IDLE is ignored.
//  - Latency: START sampled at edge k; O_VALID=1 after edge k+2.
//  - Handshake: a beat transfers on an edge with O_VALID & I_DMA_READY. Address
//    outputs and O_LAST are registered and stay stable while O_VALID & !READY.
//    The next beat is presented the cycle after a transfer; no bubbles.
//  - Source pixel (r,c), r<H, c<W: SRC = SRC_BASE + (r*W+c)*CH.
//  - Destination index (times CH, plus DST_BASE):
//    rot0: r*W+c; rot1: c*H+(H-1-r); rot2: (H-1-r)*W+(W-1-c);
//    rot3: (W-1-c)*H+r.
//  - SETUP computes initial dst, column step (+CH, +H*CH, -CH, -H*CH) and row
//    step of the row-start pointer (+W*CH, -CH, -W*CH, +CH). RUN uses adds only.
//  - Products are formed at ADDR_W bits; overflow wraps silently.
//  - O_LAST=1 on beat (H-1,W-1); H=W=1 gives a single beat with O_LAST=1.
//  - DONE: O_DONE=1 for exactly one cycle; O_BUSY drops the next cycle.
// CONFIGURATION
//  ROT_MIRROR_EN defined: adds input I_MIRROR (1 bit, sampled on start). When 1,
//    dst is computed as for source pixel (r, W-1-c), i.e. horizontal flip before
//    rotation; source order is unchanged. SETUP adjusts steps; RUN is unchanged.
//  ROT_MIRROR_EN undefined: port absent; behaviour is as if I_MIRROR=0.
// TESTING (CHANNELS=1, H=2, W=3, SRC_BASE=0x000, DST_BASE=0x100, READY=1
//  unless stated; SRC sequence is 0..5 throughout)
//  1 DEG=1 DIR=0 -> DST 101,103,105,100,102,104; O_LAST on 6th; DONE 1 cycle.
//  2 DEG=2 DIR=0 -> DST 105..100 descending; DEG=1 DIR=1 -> DST 104,102,100,
//    105,103,101 (same as DEG=3 CW).
//  3 DEG=0, READY toggled 1,0,0,1,... -> addresses held during stalls; 6
//    transfers total; no duplicates or skips.
//  4 H=0 W=3 START -> no O_VALID; O_DONE and O_ERR pulse together; back to IDLE.
//  5 Reset asserted on 3rd beat -> next cycle O_VALID/O_BUSY=0, no O_DONE; new
//    START replays a full job.
//  6 CHANNELS=3, H=W=2, DEG=0 -> SRC 0,3,6,9, DST 100,103,106,109; with
//    ROT_MIRROR_EN, I_MIRROR=1 and H=2 W=3 CH=1 -> DST 102,101,100,105,104,103.

Source files
------------

// File: rtl/rot_addr_gen_if.sv
// Beat/handshake bundle between the rotate address generator and its DMA/controller.
// I_MIRROR exists only when ROT_MIRROR_EN is defined.
interface rot_addr_gen_if #(
    parameter int unsigned DIM_W  = 16,
    parameter int unsigned ADDR_W = 32
) ();
    logic              I_START;
    logic [DIM_W-1:0]  I_HEIGHT;
    logic [DIM_W-1:0]  I_WIDTH;
    logic [1:0]        I_DEGREES;
    logic              I_DIRECTION;
    logic [ADDR_W-1:0] I_SRC_BASE;
    logic [ADDR_W-1:0] I_DST_BASE;
    logic              I_DMA_READY;
`ifdef ROT_MIRROR_EN
    logic              I_MIRROR;
`endif
    logic              O_VALID;
    logic [ADDR_W-1:0] O_SRC_ADDR;
    logic [ADDR_W-1:0] O_DST_ADDR;
    logic              O_LAST;
    logic              O_BUSY;
    logic              O_DONE;
    logic              O_ERR;

    modport master (
`ifdef ROT_MIRROR_EN
        output I_MIRROR,
`endif
        output I_START, I_HEIGHT, I_WIDTH, I_DEGREES, I_DIRECTION,
        output I_SRC_BASE, I_DST_BASE, I_DMA_READY,
        input  O_VALID, O_SRC_ADDR, O_DST_ADDR, O_LAST, O_BUSY, O_DONE, O_ERR
    );

    modport slave (
`ifdef ROT_MIRROR_EN
        input  I_MIRROR,
`endif
        input  I_START, I_HEIGHT, I_WIDTH, I_DEGREES, I_DIRECTION,
        input  I_SRC_BASE, I_DST_BASE, I_DMA_READY,
        output O_VALID, O_SRC_ADDR, O_DST_ADDR, O_LAST, O_BUSY, O_DONE, O_ERR
    );
endinterface

// File: rtl/rot_addr_gen.sv
// Raster-order source walker emitting rotated destination byte addresses, one beat per transfer.
// Define ROT_MIRROR_EN to add the I_MIRROR horizontal-flip option.
module rot_addr_gen #(
    parameter int unsigned DIM_W    = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CHANNELS = 3
) (
    input logic           I_HCLK,
    input logic           I_HRESET,
    rot_addr_gen_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StSetup, StRun, StDone} state_e;

    localparam logic [ADDR_W-1:0] Ch     = ADDR_W'(CHANNELS);
    localparam logic [DIM_W-1:0]  DimOne = DIM_W'(1);

    state_e            state_q, state_d;
    logic              setup_ph_q, setup_ph_d;
    logic [DIM_W-1:0]  h_q, h_d, w_q, w_d;
    logic [1:0]        rot_q, rot_d;
    logic              mir_q, mir_d;
    logic [ADDR_W-1:0] src_base_q, src_base_d, dst_base_q, dst_base_d;
    logic [ADDR_W-1:0] hch_q, hch_d, wch_q, wch_d, hwch_q, hwch_d;
    logic [DIM_W-1:0]  r_q, r_d, c_q, c_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d, row_q, row_d;
    logic [ADDR_W-1:0] col_step_q, col_step_d, row_step_q, row_step_d;
    logic              valid_q, valid_d, last_q, last_d, err_q, err_d;

    logic              mir_in;
    logic [ADDR_W-1:0] init_off, col_base, col_step, row_step;

`ifdef ROT_MIRROR_EN
    assign mir_in = bus.I_MIRROR;
`else
    assign mir_in = 1'b0;
`endif

    // Start offset and steps from the registered products; mirror starts at the row end
    // and walks the column the other way, the row step is unaffected.
    always_comb begin
        init_off = '0;
        col_base = Ch;
        row_step = wch_q;
        unique case (rot_q)
            2'd0: begin
                init_off = mir_q ? (wch_q - Ch) : '0;
                col_base = Ch;
                row_step = wch_q;
            end
            2'd1: begin
                init_off = mir_q ? (hwch_q - Ch) : (hch_q - Ch);
                col_base = hch_q;
                row_step = '0 - Ch;
            end
            2'd2: begin
                init_off = mir_q ? (hwch_q - wch_q) : (hwch_q - Ch);
                col_base = '0 - Ch;
                row_step = '0 - wch_q;
            end
            2'd3: begin
                init_off = mir_q ? '0 : (hwch_q - hch_q);
                col_base = '0 - hch_q;
                row_step = Ch;
            end
        endcase
        col_step = mir_q ? ('0 - col_base) : col_base;
    end

    always_comb begin
        state_d    = state_q;
        setup_ph_d = setup_ph_q;
        h_d        = h_q;
        w_d        = w_q;
        rot_d      = rot_q;
        mir_d      = mir_q;
        src_base_d = src_base_q;
        dst_base_d = dst_base_q;
        hch_d      = hch_q;
        wch_d      = wch_q;
        hwch_d     = hwch_q;
        r_d        = r_q;
        c_d        = c_q;
        src_d      = src_q;
        dst_d      = dst_q;
        row_d      = row_q;
        col_step_d = col_step_q;
        row_step_d = row_step_q;
        valid_d    = valid_q;
        last_d     = last_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (bus.I_START) begin
                    h_d        = bus.I_HEIGHT;
                    w_d        = bus.I_WIDTH;
                    rot_d      = bus.I_DIRECTION ? (2'd0 - bus.I_DEGREES) : bus.I_DEGREES;
                    mir_d      = mir_in;
                    src_base_d = bus.I_SRC_BASE;
                    dst_base_d = bus.I_DST_BASE;
                    setup_ph_d = 1'b0;
                    if (bus.I_HEIGHT == '0 || bus.I_WIDTH == '0) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b0;
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                if (!setup_ph_q) begin
                    // Phase 0: the only multiplies of the job, registered before use.
                    hch_d      = ADDR_W'(h_q) * Ch;
                    wch_d      = ADDR_W'(w_q) * Ch;
                    hwch_d     = ADDR_W'(h_q) * ADDR_W'(w_q) * Ch;
                    setup_ph_d = 1'b1;
                end else begin
                    src_d      = src_base_q;
                    dst_d      = dst_base_q + init_off;
                    row_d      = dst_base_q + init_off;
                    col_step_d = col_step;
                    row_step_d = row_step;
                    r_d        = '0;
                    c_d        = '0;
                    valid_d    = 1'b1;
                    last_d     = (h_q == DimOne) && (w_q == DimOne);
                    state_d    = StRun;
                end
            end
            StRun: begin
                if (valid_q && bus.I_DMA_READY) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = StDone;
                    end else if (c_q == w_q - DimOne) begin
                        src_d  = src_q + Ch;
                        c_d    = '0;
                        r_d    = r_q + DimOne;
                        row_d  = row_q + row_step_q;
                        dst_d  = row_q + row_step_q;
                        last_d = (r_q + DimOne == h_q - DimOne) && (w_q == DimOne);
                    end else begin
                        src_d  = src_q + Ch;
                        c_d    = c_q + DimOne;
                        dst_d  = dst_q + col_step_q;
                        last_d = (r_q == h_q - DimOne) && (c_q + DimOne == w_q - DimOne);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge I_HCLK) begin
        if (I_HRESET) begin
            state_q    <= StIdle;
            setup_ph_q <= 1'b0;
            h_q        <= '0;
            w_q        <= '0;
            rot_q      <= '0;
            mir_q      <= 1'b0;
            src_base_q <= '0;
            dst_base_q <= '0;
            hch_q      <= '0;
            wch_q      <= '0;
            hwch_q     <= '0;
            r_q        <= '0;
            c_q        <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            row_q      <= '0;
            col_step_q <= '0;
            row_step_q <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            setup_ph_q <= setup_ph_d;
            h_q        <= h_d;
            w_q        <= w_d;
            rot_q      <= rot_d;
            mir_q      <= mir_d;
            src_base_q <= src_base_d;
            dst_base_q <= dst_base_d;
            hch_q      <= hch_d;
            wch_q      <= wch_d;
            hwch_q     <= hwch_d;
            r_q        <= r_d;
            c_q        <= c_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            row_q      <= row_d;
            col_step_q <= col_step_d;
            row_step_q <= row_step_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            err_q      <= err_d;
        end
    end

    assign bus.O_VALID    = valid_q;
    assign bus.O_SRC_ADDR = src_q;
    assign bus.O_DST_ADDR = dst_q;
    assign bus.O_LAST     = last_q;
    assign bus.O_BUSY     = (state_q != StIdle);
    assign bus.O_DONE     = (state_q == StDone);
    assign bus.O_ERR      = (state_q == StDone) && err_q;
endmodule

// File: tb/tb_rot_addr_gen.sv
// Bench for rot_addr_gen: queue-based address model plus directed jobs with literal checks.
// Mirror cases are compiled in when ROT_MIRROR_EN is defined.
module tb_rot_addr_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start, ready, dir_drv, sel3;
    logic [15:0] h_drv, w_drv;
    logic [1:0]  deg_drv;
    logic [31:0] sb_drv, db_drv;
`ifdef ROT_MIRROR_EN
    logic        mir_drv;
`endif

    rot_addr_gen_if #(.DIM_W(16), .ADDR_W(32)) bus1 ();
    rot_addr_gen_if #(.DIM_W(16), .ADDR_W(32)) bus3 ();

    assign bus1.I_START     = start && !sel3;
    assign bus3.I_START     = start && sel3;
    assign bus1.I_HEIGHT    = h_drv;
    assign bus3.I_HEIGHT    = h_drv;
    assign bus1.I_WIDTH     = w_drv;
    assign bus3.I_WIDTH     = w_drv;
    assign bus1.I_DEGREES   = deg_drv;
    assign bus3.I_DEGREES   = deg_drv;
    assign bus1.I_DIRECTION = dir_drv;
    assign bus3.I_DIRECTION = dir_drv;
    assign bus1.I_SRC_BASE  = sb_drv;
    assign bus3.I_SRC_BASE  = sb_drv;
    assign bus1.I_DST_BASE  = db_drv;
    assign bus3.I_DST_BASE  = db_drv;
    assign bus1.I_DMA_READY = ready;
    assign bus3.I_DMA_READY = ready;
`ifdef ROT_MIRROR_EN
    assign bus1.I_MIRROR    = mir_drv;
    assign bus3.I_MIRROR    = mir_drv;
`endif

    rot_addr_gen #(.DIM_W(16), .ADDR_W(32), .CHANNELS(1)) u_dut1 (
        .I_HCLK   (clk),
        .I_HRESET (rst),
        .bus      (bus1)
    );

    rot_addr_gen #(.DIM_W(16), .ADDR_W(32), .CHANNELS(3)) u_dut3 (
        .I_HCLK   (clk),
        .I_HRESET (rst),
        .bus      (bus3)
    );

    logic        mon_valid, mon_last, mon_busy, mon_done, mon_err;
    logic [31:0] mon_src, mon_dst;
    assign mon_valid = sel3 ? bus3.O_VALID    : bus1.O_VALID;
    assign mon_last  = sel3 ? bus3.O_LAST     : bus1.O_LAST;
    assign mon_busy  = sel3 ? bus3.O_BUSY     : bus1.O_BUSY;
    assign mon_done  = sel3 ? bus3.O_DONE     : bus1.O_DONE;
    assign mon_err   = sel3 ? bus3.O_ERR      : bus1.O_ERR;
    assign mon_src   = sel3 ? bus3.O_SRC_ADDR : bus1.O_SRC_ADDR;
    assign mon_dst   = sel3 ? bus3.O_DST_ADDR : bus1.O_DST_ADDR;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
    } beat_t;
    beat_t       expq[$];
    logic [31:0] log_src[$];
    logic [31:0] log_dst[$];
    logic [31:0] lit6[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected beats straight from the rotation formulas, in source raster order.
    function automatic void gen_expected(input int h, input int w, input int deg, input int dir,
                                         input int mir, input logic [31:0] sb,
                                         input logic [31:0] db, input int ch);
        int rot;
        rot = dir != 0 ? ((4 - deg) % 4) : deg;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int cc;
                int idx;
                beat_t b;
                cc = mir != 0 ? (w - 1 - c) : c;
                case (rot)
                    0:       idx = r * w + cc;
                    1:       idx = cc * h + (h - 1 - r);
                    2:       idx = (h - 1 - r) * w + (w - 1 - cc);
                    default: idx = (w - 1 - cc) * h + r;
                endcase
                b.src = sb + 32'((r * w + c) * ch);
                b.dst = db + 32'(idx * ch);
                expq.push_back(b);
            end
        end
    endfunction

    // Per-cycle compare: every transfer against the model, every stall for stability.
    logic        stall_q = 1'b0;
    logic [31:0] held_src, held_dst;
    logic        held_last;
    beat_t       pop_b;
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("valid held in stall", 32'(mon_valid), 32'd1);
                chk("src held in stall", mon_src, held_src);
                chk("dst held in stall", mon_dst, held_dst);
                chk("last held in stall", 32'(mon_last), 32'(held_last));
            end
            if (mon_valid && ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected beat: got src 0x%0h dst 0x%0h, expected none",
                             mon_src, mon_dst);
                end else begin
                    pop_b = expq.pop_front();
                    chk("beat src", mon_src, pop_b.src);
                    chk("beat dst", mon_dst, pop_b.dst);
                    chk("beat last", 32'(mon_last), 32'(expq.size() == 0));
                end
                log_src.push_back(mon_src);
                log_dst.push_back(mon_dst);
            end
            stall_q   = mon_valid && !ready;
            held_src  = mon_src;
            held_dst  = mon_dst;
            held_last = mon_last;
        end
    end

    task automatic run_job(input int h, input int w, input int deg, input int dir, input int mir,
                           input logic [31:0] sb, input logic [31:0] db, input int rmode,
                           input logic use3);
        bit done_seen;
        done_seen = 1'b0;
        sel3 = use3;
        expq.delete();
        log_src.delete();
        log_dst.delete();
        gen_expected(h, w, deg, dir, mir, sb, db, use3 ? 3 : 1);
        h_drv   = 16'(h);
        w_drv   = 16'(w);
        deg_drv = 2'(deg);
        dir_drv = dir != 0;
`ifdef ROT_MIRROR_EN
        mir_drv = mir != 0;
`endif
        sb_drv  = sb;
        db_drv  = db;
        ready   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy after start", 32'(mon_busy), 32'd1);
        chk("no valid after start edge", 32'(mon_valid), 32'd0);
        if (h == 0 || w == 0) begin
            chk("empty job done", 32'(mon_done), 32'd1);
            chk("empty job err", 32'(mon_err), 32'd1);
            @(posedge clk); #1;
            chk("empty job done drops", 32'(mon_done), 32'd0);
            chk("empty job busy drops", 32'(mon_busy), 32'd0);
            chk("empty job no valid", 32'(mon_valid), 32'd0);
            return;
        end
        @(posedge clk); #1;
        chk("no valid one edge later", 32'(mon_valid), 32'd0);
        @(posedge clk); #1;
        chk("valid two edges later", 32'(mon_valid), 32'd1);
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            ready = (rmode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            start = (cyc == 3);
            @(posedge clk); #1;
            if (mon_done) done_seen = 1'b1;
        end
        start = 1'b0;
        ready = 1'b1;
        chk("done reached", 32'(done_seen), 32'd1);
        chk("no err on normal job", 32'(mon_err), 32'd0);
        chk("no valid in done", 32'(mon_valid), 32'd0);
        chk("all beats consumed", 32'(expq.size()), 32'd0);
        chk("beat count", 32'(log_dst.size()), 32'(h * w));
        @(posedge clk); #1;
        chk("done is one cycle", 32'(mon_done), 32'd0);
        chk("busy drops after done", 32'(mon_busy), 32'd0);
    endtask

    task automatic chk_log6(input string nm);
        chk({nm, " count"}, 32'(log_dst.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("%s src[%0d]", nm, i), log_src[i], 32'(i));
            chk($sformatf("%s dst[%0d]", nm, i), log_dst[i], lit6[i]);
        end
    endtask

    initial begin
        start   = 1'b0;
        ready   = 1'b1;
        sel3    = 1'b0;
        h_drv   = '0;
        w_drv   = '0;
        deg_drv = '0;
        dir_drv = 1'b0;
        sb_drv  = '0;
        db_drv  = '0;
`ifdef ROT_MIRROR_EN
        mir_drv = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset valid", 32'(bus1.O_VALID), 32'd0);
        chk("reset busy", 32'(bus1.O_BUSY), 32'd0);
        chk("reset done", 32'(bus1.O_DONE), 32'd0);
        chk("reset err", 32'(bus1.O_ERR), 32'd0);
        chk("reset last", 32'(bus1.O_LAST), 32'd0);
        chk("reset src", bus1.O_SRC_ADDR, 32'd0);
        chk("reset dst", bus1.O_DST_ADDR, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Pin the model itself to the hand-derived 90 deg CW sequence.
        lit6 = '{32'h101, 32'h103, 32'h105, 32'h100, 32'h102, 32'h104};
        expq.delete();
        gen_expected(2, 3, 1, 0, 0, 32'h0, 32'h100, 1);
        for (int i = 0; i < 6; i++) chk($sformatf("model rot90 dst[%0d]", i), expq[i].dst, lit6[i]);
        expq.delete();

        run_job(2, 3, 1, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("rot90 cw");

        lit6 = '{32'h105, 32'h104, 32'h103, 32'h102, 32'h101, 32'h100};
        run_job(2, 3, 2, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("rot180 cw");

        lit6 = '{32'h104, 32'h102, 32'h100, 32'h105, 32'h103, 32'h101};
        run_job(2, 3, 1, 1, 0, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("rot90 ccw");
        run_job(2, 3, 3, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("rot270 cw");

        lit6 = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105};
        run_job(2, 3, 0, 0, 0, 32'h0, 32'h100, 1, 1'b0);
        chk_log6("rot0 stalled");

        run_job(0, 3, 0, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        run_job(4, 0, 1, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        run_job(1, 1, 2, 1, 0, 32'h40, 32'h80, 0, 1'b0);

        // Reset while the third beat is on the bus.
        sel3 = 1'b0;
        expq.delete();
        log_src.delete();
        log_dst.delete();
        gen_expected(2, 3, 0, 0, 0, 32'h0, 32'h100, 1);
        h_drv = 16'd2; w_drv = 16'd3; deg_drv = 2'd0; dir_drv = 1'b0;
        sb_drv = 32'h0; db_drv = 32'h100; ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre-reset beats", 32'(log_dst.size()), 32'd2);
        chk("third beat presented", 32'(bus1.O_VALID), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort valid", 32'(bus1.O_VALID), 32'd0);
        chk("abort busy", 32'(bus1.O_BUSY), 32'd0);
        chk("abort done", 32'(bus1.O_DONE), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no done after abort", 32'(bus1.O_DONE | bus1.O_BUSY), 32'd0);
        end
        run_job(2, 3, 0, 0, 0, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("replay after abort");

        run_job(2, 2, 0, 0, 0, 32'h0, 32'h100, 0, 1'b1);
        chk("ch3 count", 32'(log_dst.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ch3 src[%0d]", i), log_src[i], 32'(3 * i));
            chk($sformatf("ch3 dst[%0d]", i), log_dst[i], 32'h100 + 32'(3 * i));
        end

        // Larger frame with stalls and a destination base that wraps past 2^32.
        run_job(5, 7, 1, 1, 0, 32'h1000, 32'hFFFF_FFF0, 1, 1'b1);
        run_job(3, 4, 2, 0, 0, 32'h20, 32'h7FF0, 1, 1'b0);

`ifdef ROT_MIRROR_EN
        lit6 = '{32'h102, 32'h101, 32'h100, 32'h105, 32'h104, 32'h103};
        run_job(2, 3, 0, 0, 1, 32'h0, 32'h100, 0, 1'b0);
        chk_log6("mirror rot0");
        run_job(3, 4, 1, 0, 1, 32'h0, 32'h200, 1, 1'b1);
        run_job(4, 3, 1, 1, 1, 32'h0, 32'h200, 0, 1'b0);
        run_job(2, 5, 2, 0, 1, 32'h0, 32'h200, 0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
